// File: rtl/alu_control_sequencer.sv
// Hardwired Mini SRC control unit: fetch then one ALU-class execute sequence.
// Optional retired-instruction counter behind `define CU_INSTR_COUNT_EN.
module alu_control_sequencer #(
  parameter int             OPW      = 5,
  parameter int             NREG     = 16,
  parameter logic [OPW-1:0] INC_CODE = 5'b11111
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [31:0]     ir,
  output logic [OPW-1:0]  alu_control,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            pc_out,
  output logic            pc_in,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            read,
  output logic            ir_in,
  output logic            y_in,
  output logic            zhi_in,
  output logic            zlo_in,
  output logic            zhi_out,
  output logic            zlo_out,
  output logic            hi_in,
  output logic            lo_in,
  output logic            halted,
`ifdef CU_INSTR_COUNT_EN
  output logic [31:0]     instr_count,
`endif
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  state_t state, nxt;
  logic   last;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_3r, is_md, is_un, legal;
  logic [NREG-1:0] oh_a, oh_b, oh_c;
  logic       unused_ir;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_3r = (op >= 5'd3) && (op <= 5'd11);
  assign is_md = (op == 5'd15) || (op == 5'd16);
  assign is_un = (op == 5'd17) || (op == 5'd18);
  assign legal = is_3r | is_md | is_un;

  assign oh_a = NREG'(1) << ra;
  assign oh_b = NREG'(1) << rb;
  assign oh_c = NREG'(1) << rc;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt         = state;
    last        = 1'b0;
    alu_control = '0;
    rin         = '0;
    rout        = '0;
    pc_out      = 1'b0;
    pc_in       = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    read        = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    zhi_in      = 1'b0;
    zlo_in      = 1'b0;
    zhi_out     = 1'b0;
    zlo_out     = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    halted      = 1'b0;
    unique case (state)
      IDLE: if (run) nxt = T0;
      T0: begin
        pc_out      = 1'b1;
        mar_in      = 1'b1;
        alu_control = INC_CODE;
        zlo_in      = 1'b1;
        nxt         = T1;
      end
      T1: begin
        zlo_out = 1'b1;
        pc_in   = 1'b1;
        read    = 1'b1;
        mdr_in  = 1'b1;
        nxt     = T2;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        nxt     = legal ? T3 : HALT;
      end
      T3: begin
        nxt = T4;
        unique case (1'b1)
          is_md: begin
            rout = oh_a;
            y_in = 1'b1;
          end
          is_un: begin
            rout        = oh_b;
            alu_control = OPW'(op);
            zlo_in      = 1'b1;
          end
          default: begin
            rout = oh_b;
            y_in = 1'b1;
          end
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_md: begin
            rout        = oh_b;
            alu_control = OPW'(op);
            zhi_in      = 1'b1;
            zlo_in      = 1'b1;
            nxt         = T5;
          end
          is_un: begin
            zlo_out = 1'b1;
            rin     = oh_a;
            last    = 1'b1;
          end
          default: begin
            rout        = oh_c;
            alu_control = OPW'(op);
            zlo_in      = 1'b1;
            nxt         = T5;
          end
        endcase
      end
      T5: begin
        zlo_out = 1'b1;
        if (is_md) begin
          lo_in = 1'b1;
          nxt   = T6;
        end else begin
          rin  = oh_a;
          last = 1'b1;
        end
      end
      T6: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
        last    = 1'b1;
      end
      HALT: halted = 1'b1;
      default: nxt = IDLE;
    endcase
    // end of execute: chain straight into the next fetch when run is held
    if (last) nxt = run ? T0 : IDLE;
  end

  assign state_o = state;

`ifdef CU_INSTR_COUNT_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)     instr_count <= '0;
    else if (last) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: per-cycle expected
// output vectors are queued by stimulus and checked on the falling edge.
`timescale 1ns/1ps
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run;
  logic [31:0] ir;
  logic [4:0]  alu_control;
  logic [15:0] rin, rout;
  logic pc_out, pc_in, mar_in, mdr_in, mdr_out, read, ir_in, y_in;
  logic zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in, halted;
  logic [3:0]  state_o;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  alu_control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir),
    .alu_control(alu_control), .rin(rin), .rout(rout),
    .pc_out(pc_out), .pc_in(pc_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read),
    .ir_in(ir_in), .y_in(y_in), .zhi_in(zhi_in),
    .zlo_in(zlo_in), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .hi_in(hi_in), .lo_in(lo_in), .halted(halted),
`ifdef CU_INSTR_COUNT_EN
    .instr_count(instr_count),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] PC_OUT  = 14'h2000;
  localparam logic [13:0] PC_IN   = 14'h1000;
  localparam logic [13:0] MAR_IN  = 14'h0800;
  localparam logic [13:0] MDR_IN  = 14'h0400;
  localparam logic [13:0] MDR_OUT = 14'h0200;
  localparam logic [13:0] READ    = 14'h0100;
  localparam logic [13:0] IR_IN   = 14'h0080;
  localparam logic [13:0] Y_IN    = 14'h0040;
  localparam logic [13:0] ZHI_IN  = 14'h0020;
  localparam logic [13:0] ZLO_IN  = 14'h0010;
  localparam logic [13:0] ZHI_OUT = 14'h0008;
  localparam logic [13:0] ZLO_OUT = 14'h0004;
  localparam logic [13:0] HI_IN   = 14'h0002;
  localparam logic [13:0] LO_IN   = 14'h0001;
  localparam logic [55:0] ZERO    = 56'h0;

  localparam logic [31:0] I_SHR = 32'h2891_8000;
  localparam logic [31:0] I_MUL = 32'h7B38_0000;
  localparam logic [31:0] I_NOT = 32'h9090_0000;
  localparam logic [31:0] I_ADD = {5'b00011, 4'd4, 4'd5, 4'd6, 15'd0};

  int checks = 0;
  int failures = 0;
  int tag = 0;
  logic [55:0] exp_q[$];
  int          tag_q[$];
  logic [55:0] m_exp;
  int          m_tag;

  wire [55:0] act = {state_o, halted, alu_control, rin, rout,
                     pc_out, pc_in, mar_in, mdr_in, mdr_out, read,
                     ir_in, y_in, zhi_in, zlo_in, zhi_out, zlo_out,
                     hi_in, lo_in};

  function automatic logic [55:0] v(input logic [3:0] s,
                                    input logic h,
                                    input logic [4:0] a,
                                    input logic [15:0] ri,
                                    input logic [15:0] ro,
                                    input logic [13:0] sb);
    return {s, h, a, ri, ro, sb};
  endfunction

  task automatic push(input logic [55:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tag++;
  endtask

  task automatic step(input logic [55:0] e);
    @(posedge clk);
    #1;
    push(e);
  endtask

  task automatic fetch(input logic [31:0] nir);
    step(v(4'd1, 0, 5'b11111, 0, 0, PC_OUT | MAR_IN | ZLO_IN));
    ir = nir;
    step(v(4'd2, 0, 0, 0, 0, ZLO_OUT | PC_IN | READ | MDR_IN));
    step(v(4'd3, 0, 0, 0, 0, MDR_OUT | IR_IN));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      checks++;
      if (act !== m_exp) begin
        failures++;
        $display("FAIL step%0d got=%h exp=%h", m_tag, act, m_exp);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b0;
    run = 1'b0;
    ir  = I_SHR;
    #2 push(ZERO);
    #10;
    clr = 1'b1;
    run = 1'b1;
    fetch(I_SHR);
    step(v(4'd4, 0, 0, 0, 16'h0004, Y_IN));
    step(v(4'd5, 0, 5'b00101, 0, 16'h0008, ZLO_IN));
    step(v(4'd6, 0, 0, 16'h0002, 0, ZLO_OUT));
    fetch(I_MUL);
    step(v(4'd4, 0, 0, 0, 16'h0040, Y_IN));
    step(v(4'd5, 0, 5'b01111, 0, 16'h0080, ZHI_IN | ZLO_IN));
    step(v(4'd6, 0, 0, 0, 0, ZLO_OUT | LO_IN));
    step(v(4'd7, 0, 0, 0, 0, ZHI_OUT | HI_IN));
    fetch(I_NOT);
    step(v(4'd4, 0, 5'b10010, 0, 16'h0004, ZLO_IN));
    step(v(4'd5, 0, 0, 16'h0002, 0, ZLO_OUT | RIN_NONE()));
    fetch(32'h0);
    repeat (10) step(v(4'd8, 1, 0, 0, 0, 0));
    @(posedge clk);
    #2 clr = 1'b0;
    #1 push(ZERO);
    #3 clr = 1'b1;
    run = 1'b0;
    step(ZERO);
    run = 1'b1;
    fetch(I_ADD);
    step(v(4'd4, 0, 0, 0, 16'h0020, Y_IN));
    @(posedge clk);
    #2 clr = 1'b0;
    #1 push(ZERO);
    #3 clr = 1'b1;
    fetch(I_ADD);
    step(v(4'd4, 0, 0, 0, 16'h0020, Y_IN));
    step(v(4'd5, 0, 5'b00011, 0, 16'h0040, ZLO_IN));
    run = 1'b0;
    step(v(4'd6, 0, 0, 16'h0010, 0, ZLO_OUT));
    step(ZERO);
    step(ZERO);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
`ifdef CU_INSTR_COUNT_EN
    checks++;
    if (instr_count !== 32'd1) begin
      failures++;
      $display("FAIL instr_count got=%0d exp=1", instr_count);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [13:0] RIN_NONE();
    return 14'h0;
  endfunction

endmodule
